// File: rtl/exu_div.sv
// -----------------------------------------------------------------------------
// exu_div -- multi-cycle integer divider for the EXU (DIV/DIVU/REM/REMU)
//
// Radix-2 restoring division producing one quotient bit per clock. Signed
// operands are converted to magnitudes up front and the result signs are
// restored in a single fix-up cycle. Divide-by-zero and MIN_INT / -1 are
// resolved without iterating and are reported through dz / of.
//
// Handshake (start / busy / done):
//   start is sampled only while the divider is idle. An accepted start raises
//   busy on the same edge. busy stays high until the edge that produces the
//   result. On that edge busy drops and done rises for exactly one cycle.
//   start seen while busy is dropped (there is no queue). The done cycle is
//   already idle, so a start presented there is accepted. flush overrides
//   everything, including a simultaneous start: the next edge returns to
//   idle with busy=0 and no done, and the result registers keep their values.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      operation request (sampled in IDLE only)
//   sign       in   1      1 = signed, 0 = unsigned (sampled with start)
//   dividend   in   WIDTH  numerator (sampled with start)
//   divisor    in   WIDTH  denominator (sampled with start)
//   flush      in   1      abort the current operation
//   busy       out  1      operation accepted and not yet done
//   done       out  1      one-cycle result-valid pulse
//   quotient   out  WIDTH  quotient, truncated toward zero (held)
//   remainder  out  WIDTH  remainder, sign follows dividend (held)
//   dz         out  1      divisor was zero (held with results)
//   of         out  1      signed overflow MIN_INT / -1 (held with results)
//   dbg_state  out  2      current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 SPEC)
// -----------------------------------------------------------------------------
module exu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             of,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_SPEC = 2'd3
    } state_t;

    state_t state, state_next;

    // Working registers
    logic [WIDTH-1:0] rem_r;     // partial remainder (magnitude)
    logic [WIDTH-1:0] quo_r;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_r;     // divisor magnitude
    logic [CW-1:0]    cnt;       // iterations remaining
    logic             neg_q;
    logic             neg_r;
    logic             pend_dz;   // flags for the special-case path, published at SPEC
    logic             pend_of;

    // Operand classification on the request inputs
    logic             is_zero;
    logic             is_ovf;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

    assign is_zero = (divisor == ZERO);
    assign is_ovf  = sign && (dividend == MIN_INT) && (divisor == ONES);

    // The magnitude of MIN_INT wraps back to 1<<(WIDTH-1), which is exactly
    // the right unsigned value, so no special handling is needed.
    assign dvd_abs = (sign && dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
    assign dvs_abs = (sign && divisor[WIDTH-1])  ? (~divisor + ONE)  : divisor;

    // One restoring step: shift {rem, quo} left and try to subtract.
    // A set bit WIDTH in the trial difference is the borrow (trial < 0).
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_r};

    assign dbg_state = state;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (is_zero || is_ovf) ? S_SPEC : S_CALC;
                end
            end
            S_CALC: begin
                // The edge that takes cnt from 1 to 0 is the last iteration.
                if (cnt == CNT_ONE) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_IDLE;
            S_SPEC:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= ZERO;
            remainder <= ZERO;
            dz        <= 1'b0;
            of        <= 1'b0;
            rem_r     <= ZERO;
            quo_r     <= ZERO;
            dvs_r     <= ZERO;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            pend_dz   <= 1'b0;
            pend_of   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            busy    <= 1'b1;
                            dz      <= 1'b0;
                            of      <= 1'b0;
                            pend_dz <= 1'b0;
                            pend_of <= 1'b0;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            if (is_zero) begin
                                quo_r   <= ONES;
                                rem_r   <= dividend;
                                pend_dz <= 1'b1;
                            end else if (is_ovf) begin
                                quo_r   <= MIN_INT;
                                rem_r   <= ZERO;
                                pend_of <= 1'b1;
                            end else begin
                                quo_r <= dvd_abs;
                                rem_r <= ZERO;
                                dvs_r <= dvs_abs;
                                cnt   <= CNT_INIT;
                                neg_q <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                                neg_r <= sign && dividend[WIDTH-1];
                            end
                        end
                    end
                    S_CALC: begin
                        rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
                        cnt   <= cnt - CNT_ONE;
                    end
                    S_FIX: begin
                        quotient  <= neg_q ? (~quo_r + ONE) : quo_r;
                        remainder <= neg_r ? (~rem_r + ONE) : rem_r;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                    S_SPEC: begin
                        quotient  <= quo_r;
                        remainder <= rem_r;
                        dz        <= pend_dz;
                        of        <= pend_of;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
